// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for the 3x3 sliding-window generator.
// The source drives pixels (master); the generator drives windows (slave).
interface conv_window_gen_if;
    logic [7:0]            pixel_in;
    logic                  pixel_valid;
    logic [0:2][0:2][7:0]  window;
    logic                  window_valid;
    logic                  frame_done;

    modport master (
        output pixel_in,
        output pixel_valid,
        input  window,
        input  window_valid,
        input  frame_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output window,
        output window_valid,
        output frame_done
    );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers feed the right column
// of a shifting 3x3 register window, one raster pixel per accepted cycle.
module conv_window_gen #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic            clk,
    input  logic            reset,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic {FILL, STREAM} state_e;

    state_e               state_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [7:0]           lb1_q [IMG_WIDTH];
    logic [7:0]           lb2_q [IMG_WIDTH];
    logic [0:2][0:2][7:0] win_q;
    logic                 valid_q;
    logic                 done_q;

    logic [7:0]    rd1;
    logic [7:0]    rd2;
    logic          col_end;
    logic          frame_end;
    logic [CW-1:0] col_d;
    logic [RW-1:0] row_d;

    assign rd1       = lb1_q[col_q];
    assign rd2       = lb2_q[col_q];
    assign col_end   = (col_q == COL_LAST);
    assign frame_end = col_end && (row_q == ROW_LAST);

    always_comb begin
        col_d = col_q + CW'(1);
        row_d = row_q;
        if (col_end) begin
            col_d = '0;
            row_d = frame_end ? '0 : row_q + RW'(1);
        end
    end

    // Line buffers carry no reset: rows 0/1 always overwrite them before use.
    always_ff @(posedge clk) begin
        if (bus.pixel_valid) begin
            lb2_q[col_q] <= rd1;
            lb1_q[col_q] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.pixel_valid) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= rd2;
                win_q[1][2] <= rd1;
                win_q[2][2] <= bus.pixel_in;
                col_q <= col_d;
                row_q <= row_d;
                // Columns 0/1 still hold the previous row's tail.
                valid_q <= (state_q == STREAM) && (col_q >= COL_TWO);
                unique case (state_q)
                    FILL: begin
                        if (col_end && row_q == ROW_ONE)
                            state_q <= STREAM;
                    end
                    STREAM: begin
                        if (frame_end) begin
                            state_q <= FILL;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign bus.window       = win_q;
    assign bus.window_valid = valid_q;
    assign bus.frame_done   = done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 5x5 frames and a 4x3 frame.
// Pixels are driven on the falling edge, outputs sampled 1ns after rising.
module tb_conv_window_gen;
    typedef logic [0:2][0:2][7:0] win_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_gen_if b5();
    conv_window_gen_if b43();

    conv_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) u5 (
        .clk(clk), .reset(rst), .bus(b5.slave)
    );
    conv_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) u43 (
        .clk(clk), .reset(rst), .bus(b43.slave)
    );

    int checks = 0;
    int failures = 0;

    function automatic win_t mkw(input int a0, a1, a2, a3, a4,
                                 a5, a6, a7, a8);
        win_t w;
        w[0][0] = a0[7:0]; w[0][1] = a1[7:0]; w[0][2] = a2[7:0];
        w[1][0] = a3[7:0]; w[1][1] = a4[7:0]; w[1][2] = a5[7:0];
        w[2][0] = a6[7:0]; w[2][1] = a7[7:0]; w[2][2] = a8[7:0];
        return w;
    endfunction

    // Image value at (r,c) is base + r*w + c; window anchored at (r,c).
    function automatic win_t expw(input int base, input int w,
                                  input int r, input int c);
        win_t x;
        int v;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                v = base + (r - 2 + i) * w + (c - 2 + j);
                x[i][j] = v[7:0];
            end
        return x;
    endfunction

    task automatic push5(input int v, input logic vld);
        @(negedge clk);
        b5.pixel_in    = v[7:0];
        b5.pixel_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic push43(input int v, input logic vld);
        @(negedge clk);
        b43.pixel_in    = v[7:0];
        b43.pixel_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b5.pixel_valid  = 1'b0;
        b5.pixel_in     = 8'd0;
        b43.pixel_valid = 1'b0;
        b43.pixel_in    = 8'd0;
        #12;
        checks++;
        if (b5.window !== '0) begin
            failures++;
            $display("FAIL reset_window got=%h exp=0", b5.window);
        end
        checks++;
        if (b5.window_valid !== 1'b0 || b5.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b exp=00",
                     b5.window_valid, b5.frame_done);
        end
        checks++;
        if (b43.window !== '0 || b43.window_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_43 got=%h/%b exp=0/0",
                     b43.window, b43.window_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_gapless();
        int nv = 0;
        int r, c;
        logic ev, ef;
        for (int p = 0; p < 25; p++) begin
            r = p / 5;
            c = p % 5;
            push5(p, 1'b1);
            ev = (r >= 2 && c >= 2);
            ef = (p == 24);
            checks++;
            if (b5.window_valid !== ev) begin
                failures++;
                $display("FAIL gapless_valid p=%0d got=%b exp=%b",
                         p, b5.window_valid, ev);
            end
            checks++;
            if (b5.frame_done !== ef) begin
                failures++;
                $display("FAIL gapless_done p=%0d got=%b exp=%b",
                         p, b5.frame_done, ef);
            end
            if (ev) begin
                nv++;
                checks++;
                if (b5.window !== expw(0, 5, r, c)) begin
                    failures++;
                    $display("FAIL gapless_win p=%0d got=%h exp=%h",
                             p, b5.window, expw(0, 5, r, c));
                end
            end
            if (p == 12) begin
                checks++;
                if (b5.window !== mkw(0, 1, 2, 5, 6, 7, 10, 11, 12)) begin
                    failures++;
                    $display("FAIL first_win got=%h", b5.window);
                end
            end
            if (p == 17) begin
                checks++;
                if (b5.window !== mkw(5, 6, 7, 10, 11, 12, 15, 16, 17)) begin
                    failures++;
                    $display("FAIL rowbound_win got=%h", b5.window);
                end
            end
            if (p == 24) begin
                checks++;
                if (b5.window !== mkw(12, 13, 14, 17, 18, 19, 22, 23, 24)) begin
                    failures++;
                    $display("FAIL last_win got=%h", b5.window);
                end
            end
        end
        checks++;
        if (nv != 9) begin
            failures++;
            $display("FAIL gapless_count got=%0d exp=9", nv);
        end
        push5(0, 1'b0);
        checks++;
        if (b5.window_valid !== 1'b0 || b5.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_flags got=%b%b exp=00",
                     b5.window_valid, b5.frame_done);
        end
    endtask

    task automatic test_gapped();
        int nv = 0;
        int r, c;
        logic ev;
        win_t held;
        for (int p = 0; p < 25; p++) begin
            r = p / 5;
            c = p % 5;
            push5(p, 1'b1);
            ev = (r >= 2 && c >= 2);
            checks++;
            if (b5.window_valid !== ev) begin
                failures++;
                $display("FAIL gapped_valid p=%0d got=%b exp=%b",
                         p, b5.window_valid, ev);
            end
            if (ev) begin
                nv++;
                checks++;
                if (b5.window !== expw(0, 5, r, c)) begin
                    failures++;
                    $display("FAIL gapped_win p=%0d got=%h exp=%h",
                             p, b5.window, expw(0, 5, r, c));
                end
            end
            held = b5.window;
            push5(8'hEE, 1'b0);
            checks++;
            if (b5.window_valid !== 1'b0 || b5.frame_done !== 1'b0
                || b5.window !== held) begin
                failures++;
                $display("FAIL gapped_hold p=%0d got=%b%b/%h exp=00/%h",
                         p, b5.window_valid, b5.frame_done,
                         b5.window, held);
            end
        end
        checks++;
        if (nv != 9) begin
            failures++;
            $display("FAIL gapped_count got=%0d exp=9", nv);
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        int r, c;
        logic ev;
        for (int p = 0; p < 9; p++) push5(p, 1'b1);
        @(negedge clk);
        b5.pixel_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (b5.window !== '0 || b5.window_valid !== 1'b0
            || b5.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got=%h/%b%b exp=0/00",
                     b5.window, b5.window_valid, b5.frame_done);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (b5.window !== '0 || b5.window_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_hold got=%h/%b exp=0/0",
                     b5.window, b5.window_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 25; p++) begin
            r = p / 5;
            c = p % 5;
            push5(100 + p, 1'b1);
            ev = (r >= 2 && c >= 2);
            checks++;
            if (b5.window_valid !== ev || b5.frame_done !== (p == 24)) begin
                failures++;
                $display("FAIL midrst_flags p=%0d got=%b%b exp=%b%b",
                         p, b5.window_valid, b5.frame_done, ev, p == 24);
            end
            if (ev) begin
                nv++;
                checks++;
                if (b5.window !== expw(100, 5, r, c)) begin
                    failures++;
                    $display("FAIL midrst_win p=%0d got=%h exp=%h",
                             p, b5.window, expw(100, 5, r, c));
                end
            end
            if (p == 12) begin
                checks++;
                if (b5.window !== mkw(100, 101, 102, 105, 106, 107,
                                      110, 111, 112)) begin
                    failures++;
                    $display("FAIL midrst_first got=%h", b5.window);
                end
            end
        end
        checks++;
        if (nv != 9) begin
            failures++;
            $display("FAIL midrst_count got=%0d exp=9", nv);
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        int nfd = 0;
        int r, c, base;
        logic ev;
        for (int f = 0; f < 2; f++) begin
            base = (f == 0) ? 0 : 50;
            for (int p = 0; p < 25; p++) begin
                r = p / 5;
                c = p % 5;
                push5(base + p, 1'b1);
                ev = (r >= 2 && c >= 2);
                if (b5.frame_done === 1'b1) nfd++;
                checks++;
                if (b5.window_valid !== ev) begin
                    failures++;
                    $display("FAIL b2b_valid f=%0d p=%0d got=%b exp=%b",
                             f, p, b5.window_valid, ev);
                end
                if (ev) begin
                    nv++;
                    checks++;
                    if (b5.window !== expw(base, 5, r, c)) begin
                        failures++;
                        $display("FAIL b2b_win f=%0d p=%0d got=%h exp=%h",
                                 f, p, b5.window, expw(base, 5, r, c));
                    end
                end
                if (f == 1 && p == 12) begin
                    checks++;
                    if (b5.window !== mkw(50, 51, 52, 55, 56, 57,
                                          60, 61, 62)) begin
                        failures++;
                        $display("FAIL b2b_first got=%h", b5.window);
                    end
                end
            end
        end
        push5(0, 1'b0);
        checks++;
        if (nv != 18 || nfd != 2) begin
            failures++;
            $display("FAIL b2b_counts got=%0d/%0d exp=18/2", nv, nfd);
        end
    endtask

    task automatic test_nonsquare();
        int nv = 0;
        int nfd = 0;
        for (int p = 0; p < 12; p++) begin
            push43(p, 1'b1);
            if (b43.window_valid === 1'b1) nv++;
            if (b43.frame_done === 1'b1) nfd++;
            if (p == 10) begin
                checks++;
                if (b43.window_valid !== 1'b1 || b43.frame_done !== 1'b0
                    || b43.window !== mkw(0, 1, 2, 4, 5, 6, 8, 9, 10)) begin
                    failures++;
                    $display("FAIL ns_win1 got=%b%b/%h",
                             b43.window_valid, b43.frame_done, b43.window);
                end
            end
            if (p == 11) begin
                checks++;
                if (b43.window_valid !== 1'b1 || b43.frame_done !== 1'b1
                    || b43.window !== mkw(1, 2, 3, 5, 6, 7, 9, 10, 11)) begin
                    failures++;
                    $display("FAIL ns_win2 got=%b%b/%h",
                             b43.window_valid, b43.frame_done, b43.window);
                end
            end
        end
        push43(0, 1'b0);
        checks++;
        if (nv != 2 || nfd != 1) begin
            failures++;
            $display("FAIL ns_counts got=%0d/%0d exp=2/1", nv, nfd);
        end
    endtask

    initial begin
        test_reset();
        test_gapless();
        test_gapped();
        test_reset_mid();
        test_back_to_back();
        test_nonsquare();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
